// File: rtl/readout_stream_multi_pkg.sv
// Shared definitions for the multi-channel readout streamer: sweep FSM
// encoding and the channel-index width helper.
package readout_stream_multi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;

    // Channel index width; a single channel still gets a 1-bit select.
    function automatic int chan_width(input int nchan);
        return (nchan <= 1) ? 1 : $clog2(nchan);
    endfunction

endpackage

// File: rtl/readout_stream_multi_if.sv
// Readout-memory bus plus output stream of the multi-channel streamer.
// master = streamer side, slave = memories/packetiser side.
interface readout_stream_multi_if #(
    parameter int NCHAN         = 4,
    parameter int READOUT_WIDTH = 9,
    parameter int DATA_WIDTH    = 32
);
    import readout_stream_multi_pkg::*;

    localparam int CW = chan_width(NCHAN);

    logic [NCHAN-1:0]            readoutActive;
    logic [NCHAN-1:0]            readoutValid;
    logic [READOUT_WIDTH-1:0]    readoutAddress;
    logic [CW-1:0]               readoutSelect;
    logic [NCHAN*DATA_WIDTH-1:0] readoutData;
    logic [NCHAN-1:0]            readoutPresent;
    logic [CW-1:0]               m_channel;
    logic [READOUT_WIDTH-1:0]    m_index;
    logic [DATA_WIDTH-1:0]       m_data;
    logic                        m_present;
    logic                        m_last;
    logic                        m_valid;
    logic                        m_ready;
    logic [15:0]                 overrunCount;

    modport master (
        input  readoutActive, readoutValid, readoutData, readoutPresent, m_ready,
        output readoutAddress, readoutSelect, m_channel, m_index, m_data,
               m_present, m_last, m_valid, overrunCount
    );

    modport slave (
        output readoutActive, readoutValid, readoutData, readoutPresent, m_ready,
        input  readoutAddress, readoutSelect, m_channel, m_index, m_data,
               m_present, m_last, m_valid, overrunCount
    );

endinterface

// File: rtl/readout_stream_multi_fifo.sv
// Synchronous first-word-fall-through FIFO; o_count lets the producer
// reserve space for reads it has already launched.
module readout_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // A pop frees the slot in the same cycle, so a write into a full FIFO is
    // accepted when it coincides with a read.
    assign w_pop  = i_rd_en && (r_count != '0);
    assign w_push = i_wr_en && ((r_count != (AW+1)'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is cleared too, so the read port shows
            // zeros right after reset instead of stale entries.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/readout_stream_multi.sv
// Multi-channel readout streamer: round-robin sweeps of per-channel readout
// memories over a shared bus, credit-limited into a backpressured stream.
module readout_stream_multi
    import readout_stream_multi_pkg::*;
#(
    parameter int NCHAN         = 4,
    parameter int READOUT_WIDTH = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 1,
    parameter int FIFO_DEPTH    = 8
) (
    input logic                   clk,
    input logic                   rst,
    readout_stream_multi_if.master bus
);
    localparam int CW   = chan_width(NCHAN);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [READOUT_WIDTH-1:0] ADDR_LAST = '1;

    typedef struct packed {
        logic                     valid;
        logic                     last;
        logic [CW-1:0]            chan;
        logic [READOUT_WIDTH-1:0] addr;
    } issue_t;

    typedef struct packed {
        logic                     last;
        logic                     present;
        logic [CW-1:0]            chan;
        logic [READOUT_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0]    data;
    } entry_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [NCHAN-1:0]         r_valid_d;
    logic [NCHAN-1:0]         r_active_d;
    logic [NCHAN-1:0]         r_pending;
    logic [NCHAN-1:0]         w_trig;
    logic [NCHAN-1:0]         w_clr;
    logic [NCHAN-1:0]         w_overrun_hits;
    logic [CW-1:0]            r_last_chan;
    logic [CW-1:0]            r_select;
    logic [CW-1:0]            w_next_chan;
    logic [CW-1:0]            w_up_chan;
    logic [CW-1:0]            w_wrap_chan;
    logic                     w_up_found;
    logic                     w_found;
    logic                     w_start;
    logic                     w_issue;
    logic                     w_sweep_done;
    logic [READOUT_WIDTH-1:0] r_addr;
    logic [15:0]              r_overrun;
    logic [4:0]               w_hit_count;
    logic [16:0]              w_overrun_sum;
    issue_t                   r_pipe [READ_LATENCY];
    issue_t                   w_ret;
    logic [DATA_WIDTH-1:0]    w_ret_data;
    logic                     w_ret_present;
    logic [CNTW-1:0]          w_fifo_count;
    logic [CNTW-1:0]          w_free;
    logic [CNTW-1:0]          w_inflight;
    logic                     w_fifo_empty;
    logic                     w_wr_en;
    logic                     w_rd_en;
    entry_t                   w_wr_entry;
    entry_t                   w_rd_entry;

    assign w_trig = (bus.readoutValid & ~r_valid_d) | (~bus.readoutActive & r_active_d);

    // Round-robin pick: lowest pending channel above the last served one,
    // otherwise wrap to the lowest pending channel overall.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_up_chan   = '0;
        w_wrap_chan = '0;
        w_up_found  = 1'b0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_wrap_chan = CW'(i);
                if (CW'(i) > r_last_chan) begin
                    w_up_chan  = CW'(i);
                    w_up_found = 1'b1;
                end
            end
        end
        w_found     = |r_pending;
        w_next_chan = w_up_found ? w_up_chan : w_wrap_chan;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_found)      w_state_next = ST_SWEEP;
            ST_SWEEP: if (w_sweep_done) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // Credit rule: only issue while free FIFO slots exceed reads in flight.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + CNTW'(r_pipe[i].valid);
        end
        w_free       = CNTW'(FIFO_DEPTH) - w_fifo_count;
        w_start      = (r_state == ST_IDLE) && w_found;
        w_issue      = (r_state == ST_SWEEP) && (w_free > w_inflight);
        w_sweep_done = w_issue && (r_addr == ADDR_LAST);
    end

    always_comb begin
        w_clr       = '0;
        w_hit_count = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_clr[i] = w_start && (CW'(i) == w_next_chan);
        end
        w_overrun_hits = w_trig & r_pending & ~w_clr;
        for (int i = 0; i < NCHAN; i++) begin
            w_hit_count = w_hit_count + 5'(w_overrun_hits[i]);
        end
        w_overrun_sum = {1'b0, r_overrun} + 17'(w_hit_count);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_d   <= '0;
            r_active_d  <= '0;
            r_pending   <= '0;
            r_overrun   <= '0;
            r_last_chan <= CW'(NCHAN - 1);
            r_select    <= '0;
            r_addr      <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_valid_d  <= bus.readoutValid;
            r_active_d <= bus.readoutActive;
            r_pending  <= (r_pending & ~w_clr) | w_trig;
            r_overrun  <= w_overrun_sum[16] ? OVERRUN_MAX : w_overrun_sum[15:0];
            if (w_start) begin
                r_select    <= w_next_chan;
                r_last_chan <= w_next_chan;
                r_addr      <= '0;
            end else if (w_issue && !w_sweep_done) begin
                r_addr <= r_addr + READOUT_WIDTH'(1);
            end
            r_pipe[0] <= '{valid: w_issue, last: w_sweep_done, chan: r_select, addr: r_addr};
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_ret = r_pipe[READ_LATENCY-1];

    always_comb begin
        w_ret_data    = '0;
        w_ret_present = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (CW'(i) == w_ret.chan) begin
                w_ret_data    = bus.readoutData[i*DATA_WIDTH +: DATA_WIDTH];
                w_ret_present = bus.readoutPresent[i];
            end
        end
    end

    // Absent entries are dropped, but the end-of-sweep marker always goes out.
    assign w_wr_en    = w_ret.valid && (w_ret_present || w_ret.last);
    assign w_wr_entry = '{last: w_ret.last, present: w_ret_present, chan: w_ret.chan,
                          idx: w_ret.addr, data: w_ret_data};
    assign w_rd_en    = !w_fifo_empty && bus.m_ready;

    readout_stream_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_rd_entry),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign bus.readoutAddress = r_addr;
    assign bus.readoutSelect  = r_select;
    assign bus.m_channel      = w_rd_entry.chan;
    assign bus.m_index        = w_rd_entry.idx;
    assign bus.m_data         = w_rd_entry.data;
    assign bus.m_present      = w_rd_entry.present;
    assign bus.m_last         = w_rd_entry.last;
    assign bus.m_valid        = !w_fifo_empty;
    assign bus.overrunCount   = r_overrun;

endmodule

// File: tb/tb_readout_stream_multi.sv
// Bench for readout_stream_multi: a READ_LATENCY=1 instance for the sweep,
// arbitration, overrun and reset scenarios, and a READ_LATENCY=3 one under backpressure.
module tb_readout_stream_multi;
    import readout_stream_multi_pkg::*;

    localparam int NCHAN     = 4;
    localparam int RW        = 9;
    localparam int DW        = 32;
    localparam int LAST_ADDR = 511;

    typedef struct packed {
        logic [1:0]    chan;
        logic [RW-1:0] idx;
        logic [DW-1:0] data;
        logic          present;
        logic          last;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    int   present_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    readout_stream_multi_if #(.NCHAN(NCHAN), .READOUT_WIDTH(RW), .DATA_WIDTH(DW)) bus1();
    readout_stream_multi_if #(.NCHAN(NCHAN), .READOUT_WIDTH(RW), .DATA_WIDTH(DW)) bus3();

    readout_stream_multi #(.NCHAN(NCHAN), .READOUT_WIDTH(RW), .DATA_WIDTH(DW),
                           .READ_LATENCY(1), .FIFO_DEPTH(8)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1));

    readout_stream_multi #(.NCHAN(NCHAN), .READOUT_WIDTH(RW), .DATA_WIDTH(DW),
                           .READ_LATENCY(3), .FIFO_DEPTH(8)) u_dut3 (
        .clk (clk), .rst (rst), .bus (bus3));

    function automatic logic [DW-1:0] mem_data(input int c, input int a);
        return 32'hA500_0000 + 32'(c) * 32'h0001_0000 + 32'(a);
    endfunction

    function automatic logic mem_present(input int mode, input int a);
        return (mode == 0) || (a == 3) || (a == 10);
    endfunction

    // Readout memory models: address registered READ_LATENCY times.
    logic [RW-1:0] a1_q;
    logic [RW-1:0] a3_q [3];
    always @(posedge clk) begin
        a1_q    <= bus1.readoutAddress;
        a3_q[0] <= bus3.readoutAddress;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end

    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            bus1.readoutData[c*DW +: DW] = mem_data(c, int'(a1_q));
            bus1.readoutPresent[c]       = mem_present(present_mode, int'(a1_q));
        end
    end

    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            bus3.readoutData[c*DW +: DW] = mem_data(c, int'(a3_q[2]));
            bus3.readoutPresent[c]       = mem_present(present_mode, int'(a3_q[2]));
        end
    end

    ent_t exp1[$];
    ent_t obs1[$];
    int   obs1_cyc[$];
    ent_t exp3[$];
    ent_t obs3[$];
    ent_t hold3;
    bit   hold3_v = 1'b0;
    int   stab_viol = 0;

    function automatic ent_t cur1();
        ent_t e;
        e.chan = bus1.m_channel; e.idx = bus1.m_index; e.data = bus1.m_data;
        e.present = bus1.m_present; e.last = bus1.m_last;
        return e;
    endfunction

    function automatic ent_t cur3();
        ent_t e;
        e.chan = bus3.m_channel; e.idx = bus3.m_index; e.data = bus3.m_data;
        e.present = bus3.m_present; e.last = bus3.m_last;
        return e;
    endfunction

    function automatic string fmt(input ent_t e);
        return $sformatf("ch=%0d idx=%0d data=%h p=%b l=%b", e.chan, e.idx, e.data, e.present, e.last);
    endfunction

    // Scoreboard producer: expected entries of one sweep, queued at trigger time.
    function automatic void push_sweep(input int which, input int ch, input int mode);
        ent_t e;
        for (int a = 0; a <= LAST_ADDR; a++) begin
            if (mem_present(mode, a) || a == LAST_ADDR) begin
                e.chan = 2'(ch); e.idx = RW'(a); e.data = mem_data(ch, a);
                e.present = mem_present(mode, a); e.last = (a == LAST_ADDR);
                if (which == 1) exp1.push_back(e);
                else exp3.push_back(e);
            end
        end
    endfunction

    // Output monitors: record accepted transfers, and on dut3 flag any
    // change of a stalled entry.
    always @(negedge clk) begin
        if (!rst && bus1.m_valid && bus1.m_ready) begin
            obs1.push_back(cur1());
            obs1_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold3_v = 1'b0;
        end else begin
            if (hold3_v && (!bus3.m_valid || cur3() !== hold3)) stab_viol++;
            if (bus3.m_valid && bus3.m_ready) obs3.push_back(cur3());
            hold3_v = bus3.m_valid && !bus3.m_ready;
            hold3   = cur3();
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus1.readoutValid = '0; bus1.readoutActive = '1; bus1.m_ready = 1'b1;
        bus3.readoutValid = '0; bus3.readoutActive = '1; bus3.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp1.delete(); obs1.delete(); obs1_cyc.delete();
        exp3.delete(); obs3.delete(); stab_viol = 0;
    endtask

    task automatic pulse_valid1(input int ch);
        @(posedge clk); #1 bus1.readoutValid[ch] = 1'b1;
        @(posedge clk); #1 bus1.readoutValid[ch] = 1'b0;
    endtask

    task automatic wait_obs1(input int n, input int budget);
        for (int i = 0; i < budget && obs1.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_compared += 6;
        if (bus1.readoutAddress !== '0) begin n_mismatched++; $display("FAIL reset_addr: got %0d, expected 0", bus1.readoutAddress); end
        if (bus1.readoutSelect !== '0) begin n_mismatched++; $display("FAIL reset_select: got %0d, expected 0", bus1.readoutSelect); end
        if (bus1.m_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_valid: got %b, expected 0", bus1.m_valid); end
        if (bus1.m_data !== '0) begin n_mismatched++; $display("FAIL reset_data: got %h, expected 0", bus1.m_data); end
        if (bus1.m_last !== 1'b0) begin n_mismatched++; $display("FAIL reset_last: got %b, expected 0", bus1.m_last); end
        if (bus1.overrunCount !== 16'd0) begin n_mismatched++; $display("FAIL reset_overrun: got %0d, expected 0", bus1.overrunCount); end
    endtask

    task automatic test_single_sweep();
        int t_addr = -1;
        int t_valid = -1;
        ent_t e, o;
        do_reset();
        present_mode = 1;
        push_sweep(1, 2, 1);
        pulse_valid1(2);
        for (int i = 0; i < 700 && obs1.size() < 3; i++) begin
            @(negedge clk);
            if (t_addr < 0 && bus1.readoutSelect == 2'd2 && bus1.readoutAddress == 9'd3) t_addr = cyc;
            if (t_valid < 0 && bus1.m_valid) t_valid = cyc;
        end
        repeat (10) @(negedge clk);
        n_compared++;
        if (t_addr < 0 || t_valid - t_addr != 2) begin
            n_mismatched++;
            $display("FAIL single_latency: got %0d cycles, expected 2", t_valid - t_addr);
        end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            n_compared++;
            if (obs1.size() == 0) begin
                n_mismatched++; $display("FAIL single_entry: got nothing, expected %s", fmt(e));
            end else begin
                o = obs1.pop_front();
                if (o !== e) begin n_mismatched++; $display("FAIL single_entry: got %s, expected %s", fmt(o), fmt(e)); end
            end
        end
        n_compared++;
        if (obs1.size() != 0) begin n_mismatched++; $display("FAIL single_extra: got %0d entries, expected 0", obs1.size()); end
        present_mode = 0;
    endtask

    task automatic test_two_channels();
        ent_t e, o;
        int gap;
        do_reset();
        push_sweep(1, 1, 0);
        push_sweep(1, 3, 0);
        @(posedge clk); #1 bus1.readoutActive[1] = 1'b0; bus1.readoutActive[3] = 1'b0;
        @(posedge clk); #1 bus1.readoutActive = '1;
        wait_obs1(1024, 1300);
        repeat (10) @(negedge clk);
        n_compared += 3;
        if (obs1.size() < 1024) begin
            n_mismatched++; $display("FAIL two_timeout: got %0d entries, expected 1024", obs1.size());
            gap = -1;
        end else begin
            gap = obs1_cyc[512] - obs1_cyc[511];
        end
        if (gap != 2) begin n_mismatched++; $display("FAIL two_gap: got %0d cycles, expected 2", gap); end
        if (bus1.overrunCount !== 16'd0) begin n_mismatched++; $display("FAIL two_overrun: got %0d, expected 0", bus1.overrunCount); end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            n_compared++;
            if (obs1.size() == 0) begin
                n_mismatched++; $display("FAIL two_entry: got nothing, expected %s", fmt(e));
            end else begin
                o = obs1.pop_front();
                if (o !== e) begin n_mismatched++; $display("FAIL two_entry: got %s, expected %s", fmt(o), fmt(e)); end
            end
        end
        n_compared++;
        if (obs1.size() != 0) begin n_mismatched++; $display("FAIL two_extra: got %0d entries, expected 0", obs1.size()); end
    endtask

    task automatic test_overrun();
        ent_t e, o;
        bit reached = 1'b0;
        do_reset();
        push_sweep(1, 1, 0);
        pulse_valid1(1);
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk);
            reached = (bus1.readoutSelect == 2'd1) && (bus1.readoutAddress >= 9'd20);
        end
        n_compared++;
        if (!reached) begin n_mismatched++; $display("FAIL overrun_start: got no ch1 sweep, expected addr>=20"); end
        push_sweep(1, 0, 0);
        repeat (3) pulse_valid1(0);
        wait_obs1(1024, 1300);
        repeat (30) @(negedge clk);
        n_compared++;
        if (bus1.overrunCount !== 16'd2) begin n_mismatched++; $display("FAIL overrun_count: got %0d, expected 2", bus1.overrunCount); end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            n_compared++;
            if (obs1.size() == 0) begin
                n_mismatched++; $display("FAIL overrun_entry: got nothing, expected %s", fmt(e));
            end else begin
                o = obs1.pop_front();
                if (o !== e) begin n_mismatched++; $display("FAIL overrun_entry: got %s, expected %s", fmt(o), fmt(e)); end
            end
        end
        n_compared++;
        if (obs1.size() != 0) begin n_mismatched++; $display("FAIL overrun_extra_sweep: got %0d entries, expected 0", obs1.size()); end
    endtask

    task automatic test_reset_mid_sweep();
        ent_t e, o;
        bit reached = 1'b0;
        int valid_seen = 0;
        do_reset();
        pulse_valid1(2);
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge clk); #1;
            reached = (bus1.readoutSelect == 2'd2) && (bus1.readoutAddress == 9'd100);
        end
        n_compared++;
        if (!reached) begin n_mismatched++; $display("FAIL midrst_reach: got addr %0d, expected 100", bus1.readoutAddress); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_compared++;
        if ({bus1.readoutAddress, bus1.readoutSelect, bus1.m_channel, bus1.m_index, bus1.m_data,
             bus1.m_present, bus1.m_last, bus1.m_valid, bus1.overrunCount} !== '0) begin
            n_mismatched++;
            $display("FAIL midrst_outputs: got addr=%0d sel=%0d valid=%b %s, expected all 0",
                     bus1.readoutAddress, bus1.readoutSelect, bus1.m_valid, fmt(cur1()));
        end
        rst = 1'b0;
        exp1.delete(); obs1.delete(); obs1_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.m_valid) valid_seen++;
        end
        n_compared++;
        if (valid_seen != 0) begin n_mismatched++; $display("FAIL midrst_quiet: got %0d valid cycles, expected 0", valid_seen); end
        push_sweep(1, 2, 0);
        pulse_valid1(2);
        wait_obs1(512, 700);
        repeat (10) @(negedge clk);
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            n_compared++;
            if (obs1.size() == 0) begin
                n_mismatched++; $display("FAIL midrst_entry: got nothing, expected %s", fmt(e));
            end else begin
                o = obs1.pop_front();
                if (o !== e) begin n_mismatched++; $display("FAIL midrst_entry: got %s, expected %s", fmt(o), fmt(e)); end
            end
        end
        n_compared++;
        if (obs1.size() != 0) begin n_mismatched++; $display("FAIL midrst_extra: got %0d entries, expected 0", obs1.size()); end
    endtask

    task automatic test_backpressure();
        ent_t e, o;
        int stalls = 0;
        logic [RW-1:0] prev_addr;
        do_reset();
        push_sweep(3, 0, 0);
        @(posedge clk); #1 bus3.readoutValid[0] = 1'b1;
        @(posedge clk); #1 bus3.readoutValid[0] = 1'b0;
        prev_addr = bus3.readoutAddress;
        for (int i = 0; i < 3000 && obs3.size() < 512; i++) begin
            @(posedge clk); #1;
            bus3.m_ready = ~bus3.m_ready;
            if (bus3.readoutAddress > 9'd0 && bus3.readoutAddress < 9'(LAST_ADDR) &&
                bus3.readoutAddress == prev_addr) stalls++;
            prev_addr = bus3.readoutAddress;
        end
        repeat (20) begin
            @(posedge clk); #1 bus3.m_ready = ~bus3.m_ready;
        end
        n_compared += 2;
        if (stalls == 0) begin n_mismatched++; $display("FAIL bp_addr_stall: got 0 stalled cycles, expected >0"); end
        if (stab_viol != 0) begin n_mismatched++; $display("FAIL bp_stable: got %0d changes while stalled, expected 0", stab_viol); end
        while (exp3.size() > 0) begin
            e = exp3.pop_front();
            n_compared++;
            if (obs3.size() == 0) begin
                n_mismatched++; $display("FAIL bp_entry: got nothing, expected %s", fmt(e));
            end else begin
                o = obs3.pop_front();
                if (o !== e) begin n_mismatched++; $display("FAIL bp_entry: got %s, expected %s", fmt(o), fmt(e)); end
            end
        end
        n_compared++;
        if (obs3.size() != 0) begin n_mismatched++; $display("FAIL bp_extra: got %0d entries, expected 0", obs3.size()); end
    endtask

    initial begin
        bus1.readoutValid = '0; bus1.readoutActive = '1; bus1.m_ready = 1'b1;
        bus3.readoutValid = '0; bus3.readoutActive = '1; bus3.m_ready = 1'b0;
        test_reset();
        test_single_sweep();
        test_two_channels();
        test_overrun();
        test_reset_mid_sweep();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/readout_stream_multi.md
Name: readout_stream_multi

Overview:
- Multi-channel successor to the single-channel readout streamer.
- Watches NCHAN acquisition channels. On each channel's "new data" or "acquisition ended" event, it sweeps that channel's readout memory over a shared address bus.
- Sweeps are served in round-robin order, absorb a configurable memory read latency, and feed a backpressured stream output carrying channel, index, data and end-of-sweep.
- Sits between the per-channel acquisition buffers and the packetiser/DMA.

Parameters:
NCHAN, 4, number of acquisition channels (1..16)
READOUT_WIDTH, 9, readout address width; a sweep covers 0..2^READOUT_WIDTH-1
DATA_WIDTH, 32, readout data width
READ_LATENCY, 1, cycles from readoutAddress to readoutData/readoutPresent valid (1..4)
FIFO_DEPTH, 8, output buffer depth, power of two, must be >= READ_LATENCY+2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
readoutActive  in  NCHAN  per-channel acquisition-interval flag
readoutValid  in  NCHAN  per-channel new-data flag
readoutAddress  out  READOUT_WIDTH  shared read address, registered
readoutSelect  out  clog2(NCHAN) (min 1)  channel being read, registered
readoutData  in  NCHAN*DATA_WIDTH  per-channel read data, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
readoutPresent  in  NCHAN  per-channel entry-present flag, same latency as data
m_channel  out  clog2(NCHAN)  channel of output entry
m_index  out  READOUT_WIDTH  address of output entry
m_data  out  DATA_WIDTH  entry data
m_present  out  1  entry present flag (only meaningful with m_last)
m_last  out  1  final entry of a sweep
m_valid  out  1  output entry valid
m_ready  in  1  downstream accepts entry
overrunCount  out  16  saturating count of lost triggers

Behaviour:
- Reset: rst=1 at a clk edge clears all outputs to 0, state to ST_IDLE, pending bits, edge registers, in-flight tracking, FIFO contents and overrunCount. This also applies mid-sweep: the sweep is abandoned, no m_last is emitted and in-flight reads are discarded.
- Trigger: trig[c] = (readoutValid[c] & ~readoutValid_d[c]) | (~readoutActive[c] & readoutActive_d[c]). Both terms in one cycle count as one trigger.
- Pending:
  - trig[c] sets pending[c] at the next edge.
  - If pending[c] is already 1 and not being cleared that cycle, overrunCount increments, saturating at 0xFFFF.
  - A trigger on the channel currently being swept sets pending again, so a fresh sweep follows.
- States:
  - ST_IDLE: if any pending bit is set, choose the next pending channel round-robin, starting after the last served channel (channel 0 first after reset). Clear its pending bit, set readoutSelect and readoutAddress=0, go to ST_SWEEP.
  - ST_SWEEP: each cycle a read is issued (address held, credit consumed) only if FIFO free slots exceed reads in flight. Otherwise readoutAddress is held. After issuing the final address 2^READOUT_WIDTH-1, go to ST_IDLE. The next sweep may start while earlier reads are still in flight.
- Return path: issue info (channel, address, last flag) is carried through a READ_LATENCY-stage shift register. Data/present are muxed by the delayed channel index.
- Write rule: an entry is written to the FIFO iff present=1 or it is the final address. The final address is always written, with m_last=1 and m_present=readoutPresent.
- FIFO:
  - Registered output; m_valid=~empty.
  - Transfer on m_valid & m_ready. Output fields stay stable while m_valid=1 and m_ready=0.
  - Overflow is impossible by the credit rule. Simultaneous read and write when full or empty must work.
- Latency: readoutAddress=a at cycle t; data sampled at t+READ_LATENCY; m_valid for that entry at t+READ_LATENCY+1 if the FIFO was empty.
- Throughput: one address per cycle with m_ready=1 continuously. A full sweep takes 2^READOUT_WIDTH cycles, plus one ST_IDLE cycle between sweeps.
- Widths: readoutAddress wraps via the explicit compare, never by overflow. overrunCount saturates.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_SWEEP) and a CHAN_WIDTH = clog2(NCHAN) min-1 constant function.
- Natural sub-module: readout_stream_fifo, a synchronous FWFT FIFO parametrised in width and depth, with count output for credit.

Test Plan:
- NCHAN=4, READ_LATENCY=1, m_ready=1; rising edge on readoutValid[2], present at addresses 3 and 10 only:
  - Outputs are (ch2, idx3), (ch2, idx10), then (ch2, idx511, m_last=1, m_present=0).
  - First m_valid occurs 2 cycles after address 3 is driven.
- Falling edges of readoutActive on channels 1 and 3 in the same cycle, all entries present:
  - Channel 1 gives 512 entries ending with m_last.
  - Then channel 3 gives 512 entries with no gap beyond one idle cycle.
  - overrunCount=0.
- READ_LATENCY=3, all present, m_ready toggling 1-0 every cycle:
  - Indices 0..511 appear in order with no loss or duplication; fields stay stable while stalled.
  - readoutAddress stalls once FIFO credit is exhausted.
- Three triggers on channel 0 while channel 1 is sweeping:
  - overrunCount=2; exactly one channel-0 sweep follows.
- rst asserted at sweep address 100 with data in flight:
  - Next cycle all outputs are 0 and the FIFO is empty.
  - No m_last is emitted; a new trigger afterwards sweeps from address 0.
